// File: rtl/int_exec_unit_pipe_pkg.sv
// rtl/int_exec_unit_pipe_pkg.sv - opcode/funct3 constants and ALU-op decode for the integer execution unit
// Contents: R_TYPE/I_TYPE/B_TYPE opcodes, branch funct3 encodings, alu_op_e, decode_alu()
package int_exec_unit_pipe_pkg;

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] B_TYPE = 7'b1100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ZERO
   } alu_op_e;

   // Anything that is neither R_TYPE nor I_TYPE arith decodes to ALU_ZERO.
   // SUB exists only for R_TYPE; SRA is keyed on funct7[5] for both types.
   function automatic alu_op_e decode_alu(input logic [6:0] opc,
                                          input logic [2:0] f3,
                                          input logic       f7_b5);
      alu_op_e op;
      op = ALU_ZERO;
      if (opc == R_TYPE || opc == I_TYPE) begin
         case (f3)
            3'b000:  op = (opc == R_TYPE && f7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/int_exec_obuf.sv
// rtl/int_exec_obuf.sv - in-order result FIFO feeding the CDB request logic
// Ports: clk, rst_n (sync active-low), flush_i, push_i/push_data_i, pop_i, empty_o, head_o
module int_exec_obuf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i && !do_pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (do_pop && !push_i) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: nothing is read while the count is zero.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/int_exec_unit_pipe.sv
// rtl/int_exec_unit_pipe.sv - pipelined integer ALU/branch unit with credit-limited result buffer and CDB handshake
// Ports: clk, rst_n (sync active-low); issue_int/int_busy, Opcode/Funct3/Funct7/RS1/RS2/RD_Tag issue bus;
//        flush; cdb_req/cdb_grant handshake; cdb_data/cdb_tag/cdb_valid/cdb_branch/cdb_branch_taken result
module int_exec_unit_pipe
   import int_exec_unit_pipe_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int TAG_W      = 6,
   parameter int STAGES     = 2,
   parameter int OBUF_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_int,
   output logic             int_busy,
   input  logic [6:0]       Opcode,
   input  logic [2:0]       Funct3,
   input  logic [6:0]       Funct7,
   input  logic [XLEN-1:0]  RS1,
   input  logic [XLEN-1:0]  RS2,
   input  logic [TAG_W-1:0] RD_Tag,
   input  logic             flush,
   output logic             cdb_req,
   input  logic             cdb_grant,
   output logic [XLEN-1:0]  cdb_data,
   output logic [TAG_W-1:0] cdb_tag,
   output logic             cdb_valid,
   output logic             cdb_branch,
   output logic             cdb_branch_taken
);

   localparam int SHW   = $clog2(XLEN);
   localparam int OCC_W = $clog2(OBUF_DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0]  data;
      logic [TAG_W-1:0] tag;
      logic             valid;
      logic             branch;
      logic             taken;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   logic             accept;
   logic             pop;
   logic [OCC_W-1:0] occ_q, occ_d;
   alu_op_e          alu_op;
   logic [SHW-1:0]   shamt;
   logic [XLEN-1:0]  alu_res;
   logic             br_taken;
   entry_t           res_entry;
   entry_t           push_entry;
   entry_t           head;
   logic             push;
   logic             empty;
   logic [ENTRY_W-1:0] head_bits;
   logic             unused_funct7;

   // Busy comes from the registered count only, so a same-cycle pop never
   // unblocks an issue; this is what keeps the buffer from overflowing.
   assign int_busy = (occ_q == OCC_W'(OBUF_DEPTH));
   assign accept   = issue_int && !int_busy && !flush;
   assign pop      = cdb_req && cdb_grant;

   assign alu_op        = decode_alu(Opcode, Funct3, Funct7[5]);
   assign shamt         = RS2[SHW-1:0];
   assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

   always_comb begin
      alu_res = '0;
      case (alu_op)
         ALU_ADD:  alu_res = RS1 + RS2;
         ALU_SUB:  alu_res = RS1 - RS2;
         ALU_SLL:  alu_res = RS1 << shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(RS1) < $signed(RS2))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (RS1 < RS2)};
         ALU_XOR:  alu_res = RS1 ^ RS2;
         ALU_SRL:  alu_res = RS1 >> shamt;
         ALU_SRA:  alu_res = $signed(RS1) >>> shamt;
         ALU_OR:   alu_res = RS1 | RS2;
         ALU_AND:  alu_res = RS1 & RS2;
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      case (Funct3)
         F3_BEQ:  br_taken = (RS1 == RS2);
         F3_BNE:  br_taken = (RS1 != RS2);
         F3_BLT:  br_taken = ($signed(RS1) <  $signed(RS2));
         F3_BGE:  br_taken = ($signed(RS1) >= $signed(RS2));
         F3_BLTU: br_taken = (RS1 <  RS2);
         F3_BGEU: br_taken = (RS1 >= RS2);
         default: br_taken = 1'b0;
      endcase
   end

   // Branch outcomes carry no register write: data/tag/valid stay zero.
   always_comb begin
      res_entry = '0;
      if (Opcode == B_TYPE) begin
         res_entry.branch = 1'b1;
         res_entry.taken  = br_taken;
      end else begin
         res_entry.data  = alu_res;
         res_entry.tag   = RD_Tag;
         res_entry.valid = 1'b1;
      end
   end

   // STAGES-1 register stages between accept and the buffer write; the
   // buffer write itself is the last cycle of latency.
   generate
      if (STAGES == 1) begin : g_no_pipe
         assign push       = accept;
         assign push_entry = res_entry;
      end else begin : g_pipe
         logic [STAGES-2:0] vld_q;
         entry_t            ent_q [STAGES-1];

         always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= accept;
               for (int i = 1; i < STAGES - 1; i++) begin
                  vld_q[i] <= vld_q[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            ent_q[0] <= res_entry;
            for (int i = 1; i < STAGES - 1; i++) begin
               ent_q[i] <= ent_q[i-1];
            end
         end

         assign push       = vld_q[STAGES-2];
         assign push_entry = ent_q[STAGES-2];
      end
   endgenerate

   int_exec_obuf #(
      .WIDTH (ENTRY_W),
      .DEPTH (OBUF_DEPTH)
   ) u_obuf (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .empty_o     (empty),
      .head_o      (head_bits)
   );

   assign head = entry_t'(head_bits);

   always_comb begin
      occ_d = occ_q;
      if (accept && !pop) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (pop && !accept) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign cdb_req          = !empty;
   assign cdb_valid        = !empty && head.valid;
   assign cdb_branch       = !empty && head.branch;
   assign cdb_branch_taken = !empty && head.taken;
   assign cdb_data         = empty ? '0 : head.data;
   assign cdb_tag          = empty ? '0 : head.tag;

endmodule

// File: tb/tb_int_exec_unit_pipe.sv
// tb/tb_int_exec_unit_pipe.sv - self-checking bench for int_exec_unit_pipe against a queue-based reference model
module tb_int_exec_unit_pipe;

   localparam int XLEN       = 32;
   localparam int TAG_W      = 6;
   localparam int STAGES     = 2;
   localparam int OBUF_DEPTH = 2;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_B = 7'b1100011;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             issue_int = 1'b0;
   logic [6:0]       Opcode = '0;
   logic [2:0]       Funct3 = '0;
   logic [6:0]       Funct7 = '0;
   logic [XLEN-1:0]  RS1 = '0;
   logic [XLEN-1:0]  RS2 = '0;
   logic [TAG_W-1:0] RD_Tag = '0;
   logic             flush = 1'b0;
   logic             cdb_grant = 1'b0;
   logic             int_busy;
   logic             cdb_req;
   logic [XLEN-1:0]  cdb_data;
   logic [TAG_W-1:0] cdb_tag;
   logic             cdb_valid;
   logic             cdb_branch;
   logic             cdb_branch_taken;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   int_exec_unit_pipe #(
      .XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES), .OBUF_DEPTH(OBUF_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .issue_int(issue_int), .int_busy(int_busy),
      .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7), .RS1(RS1), .RS2(RS2),
      .RD_Tag(RD_Tag), .flush(flush), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
      .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_valid(cdb_valid),
      .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken)
   );

   typedef struct {
      logic [XLEN-1:0]  data;
      logic [TAG_W-1:0] tag;
      logic             valid;
      logic             branch;
      logic             taken;
      int               ready;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference semantics in plain integer arithmetic.
   function automatic exp_t model_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                     input logic [TAG_W-1:0] tag);
      exp_t   e;
      longint sa, sb;
      int     sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % XLEN);
      e.data = '0; e.tag = tag; e.valid = 1'b1; e.branch = 1'b0; e.taken = 1'b0; e.ready = 0;
      if (opc == OP_B) begin
         e.tag = '0; e.valid = 1'b0; e.branch = 1'b1;
         case (f3)
            3'd0: e.taken = (a == b);
            3'd1: e.taken = (a != b);
            3'd4: e.taken = (sa <  sb);
            3'd5: e.taken = (sa >= sb);
            3'd6: e.taken = (a <  b);
            3'd7: e.taken = (a >= b);
            default: e.taken = 1'b0;
         endcase
      end else if (opc == OP_R || opc == OP_I) begin
         case (f3)
            3'd0: e.data = (opc == OP_R && f7[5]) ? a - b : a + b;
            3'd1: e.data = a << sh;
            3'd2: e.data = (sa < sb) ? 1 : 0;
            3'd3: e.data = (a < b) ? 1 : 0;
            3'd4: e.data = a ^ b;
            3'd5: e.data = f7[5] ? XLEN'(sa >>> sh) : (a >> sh);
            3'd6: e.data = a | b;
            default: e.data = a & b;
         endcase
      end
      return e;
   endfunction

   // Model: q holds every accepted, not yet delivered op, i.e. the credit count.
   exp_t mdl_e;
   bit   mdl_full;
   always @(posedge clk) begin
      mdl_full = (q.size() == OBUF_DEPTH);
      if (!rst_n || flush) begin
         q.delete();
      end else begin
         if (q.size() > 0 && q[0].ready <= cyc && cdb_grant) void'(q.pop_front());
         if (issue_int && !mdl_full) begin
            mdl_e = model_op(Opcode, Funct3, Funct7, RS1, RS2, RD_Tag);
            mdl_e.ready = cyc + STAGES;
            q.push_back(mdl_e);
         end
      end
      cyc++;
   end

   bit   cmp_hv;
   exp_t cmp_h;
   logic [63:0] cmp_exp;
   always @(negedge clk) begin
      if (chk_en) begin
         cmp_hv = (q.size() > 0) && (q[0].ready <= cyc);
         if (cmp_hv) begin
            cmp_h = q[0];
            cmp_exp = {1'b1, cmp_h.valid, cmp_h.branch, cmp_h.taken, 1'(q.size() == OBUF_DEPTH), cmp_h.tag, cmp_h.data};
         end else begin
            cmp_exp = {4'b0000, 1'(q.size() == OBUF_DEPTH), {TAG_W{1'b0}}, {XLEN{1'b0}}};
         end
         chk("model_cmp", {cdb_req, cdb_valid, cdb_branch, cdb_branch_taken, int_busy, cdb_tag, cdb_data}, cmp_exp);
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
      Opcode = opc; Funct3 = f3; Funct7 = f7; RS1 = a; RS2 = b; RD_Tag = tag; issue_int = 1'b1;
   endtask

   task automatic idle();
      issue_int = 1'b0;
   endtask

   task automatic run_lit(input string nm, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                          input logic [XLEN-1:0] ed, input logic ev, input logic eb, input logic et);
      exp_t m;
      m = model_op(opc, f3, f7, a, b, tag);
      chk({nm, "_model"}, {m.data, m.valid, m.branch, m.taken}, {ed, ev, eb, et});
      cdb_grant = 1'b1;
      drive(opc, f3, f7, a, b, tag);
      next(); idle();
      chk({nm, "_early"}, cdb_req, 0);
      next();
      chk(nm, {cdb_req, cdb_valid, cdb_branch, cdb_branch_taken, cdb_tag, cdb_data},
          {1'b1, ev, eb, et, (eb ? {TAG_W{1'b0}} : tag), ed});
      next();
      chk({nm, "_once"}, cdb_req, 0);
   endtask

   function automatic logic [XLEN-1:0] rnd_val();
      logic [XLEN-1:0] specials [5];
      specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
      return $urandom();
   endfunction

   logic [6:0] r_opc;
   logic [XLEN-1:0] r_a;

   initial begin
      // Reset with an issue pending.
      rst_n = 1'b0;
      drive(OP_R, 3'd0, 7'd0, 32'd1, 32'd2, 6'd1);
      next();
      chk_en = 1'b1;
      chk("reset_c1", {cdb_req, cdb_valid, cdb_branch, cdb_branch_taken, int_busy, cdb_tag, cdb_data}, 64'd0);
      next();
      chk("reset_c2", {cdb_req, cdb_valid, cdb_branch, cdb_branch_taken, int_busy, cdb_tag, cdb_data}, 64'd0);
      rst_n = 1'b1;
      idle();
      for (int i = 0; i < 3; i++) begin
         next();
         chk("post_reset_idle", cdb_req, 0);
      end

      // Directed ALU and branch results with exact latency.
      run_lit("add",   OP_R, 3'd0, 7'h00, 32'd5,          32'd7, 6'd3,  32'd12,         1, 0, 0);
      run_lit("sub",   OP_R, 3'd0, 7'h20, 32'd3,          32'd5, 6'd4,  32'hFFFF_FFFE,  1, 0, 0);
      run_lit("sra",   OP_R, 3'd5, 7'h20, 32'h8000_0000,  32'd4, 6'd5,  32'hF800_0000,  1, 0, 0);
      run_lit("srai",  OP_I, 3'd5, 7'h20, 32'h8000_0000,  32'd4, 6'd6,  32'hF800_0000,  1, 0, 0);
      run_lit("addi_f7", OP_I, 3'd0, 7'h20, 32'd3,        32'd5, 6'd7,  32'd8,          1, 0, 0);
      run_lit("slt",   OP_R, 3'd2, 7'h00, 32'hFFFF_FFFF,  32'd1, 6'd8,  32'd1,          1, 0, 0);
      run_lit("sltu",  OP_R, 3'd3, 7'h00, 32'hFFFF_FFFF,  32'd1, 6'd9,  32'd0,          1, 0, 0);
      run_lit("other", 7'b0110111, 3'd0, 7'h00, 32'd9,    32'd9, 6'd10, 32'd0,          1, 0, 0);
      run_lit("bne",   OP_B, 3'd1, 7'h00, 32'd4,          32'd4, 6'd11, 32'd0,          0, 1, 0);
      run_lit("blt",   OP_B, 3'd4, 7'h00, 32'hFFFF_FFFF,  32'd1, 6'd12, 32'd0,          0, 1, 1);
      run_lit("bltu",  OP_B, 3'd6, 7'h00, 32'hFFFF_FFFF,  32'd1, 6'd13, 32'd0,          0, 1, 0);
      run_lit("b010",  OP_B, 3'd2, 7'h00, 32'd1,          32'd1, 6'd14, 32'd0,          0, 1, 0);

      // Backpressure: third issue is refused while two credits are held.
      cdb_grant = 1'b0;
      drive(OP_R, 3'd0, 7'h00, 32'd1, 32'd1, 6'd20);
      next(); chk("bp_busy1", int_busy, 0);
      drive(OP_R, 3'd0, 7'h00, 32'd2, 32'd2, 6'd21);
      next(); chk("bp_busy2", int_busy, 1);
      drive(OP_R, 3'd0, 7'h00, 32'd3, 32'd3, 6'd22);
      next(); idle(); chk("bp_busy3", int_busy, 1);
      next(); next(); next();
      chk("bp_head0", {cdb_req, cdb_tag, cdb_data}, {1'b1, 6'd20, 32'd2});
      cdb_grant = 1'b1;
      next(); chk("bp_head1", {cdb_req, int_busy, cdb_tag, cdb_data}, {1'b1, 1'b0, 6'd21, 32'd4});
      next(); chk("bp_drained", cdb_req, 0);

      // Flush with two in flight and a same-cycle issue.
      cdb_grant = 1'b0;
      drive(OP_R, 3'd0, 7'h00, 32'd1, 32'd0, 6'd30);
      next();
      drive(OP_R, 3'd0, 7'h00, 32'd2, 32'd0, 6'd31);
      next();
      flush = 1'b1;
      drive(OP_R, 3'd0, 7'h00, 32'd3, 32'd0, 6'd32);
      next();
      flush = 1'b0; idle();
      for (int i = 0; i < 4; i++) begin
         chk("flush_empty", {cdb_req, int_busy}, 2'b00);
         next();
      end
      drive(OP_R, 3'd0, 7'h00, 32'd4, 32'd0, 6'd33);
      next(); chk("flush_credit1", int_busy, 0);
      drive(OP_R, 3'd0, 7'h00, 32'd5, 32'd0, 6'd34);
      next(); idle(); chk("flush_credit2", int_busy, 1);

      // Hold: head stays put without grant; one grant pulse pops one entry.
      for (int i = 0; i < 5; i++) begin
         next();
         chk("hold", {cdb_req, cdb_tag, cdb_data}, {1'b1, 6'd33, 32'd4});
      end
      cdb_grant = 1'b1;
      next(); cdb_grant = 1'b0;
      chk("hold_pop1", {cdb_req, cdb_tag, cdb_data}, {1'b1, 6'd34, 32'd5});
      next();
      chk("hold_pop1_stay", {cdb_req, cdb_tag, cdb_data}, {1'b1, 6'd34, 32'd5});
      cdb_grant = 1'b1;
      next(); next();

      // Randomized traffic, checked every cycle by the model.
      for (int n = 0; n < 4000; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: r_opc = OP_R;
            4, 5, 6:    r_opc = OP_I;
            7, 8:       r_opc = OP_B;
            default:    r_opc = 7'($urandom());
         endcase
         r_a = rnd_val();
         drive(r_opc, 3'($urandom()), ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
               r_a, ($urandom_range(0, 7) == 0) ? r_a : rnd_val(), 6'($urandom()));
         issue_int = ($urandom_range(0, 3) != 0);
         cdb_grant = ($urandom_range(0, 4) < 3);
         flush     = ($urandom_range(0, 49) == 0);
         rst_n     = ($urandom_range(0, 199) != 0);
         next();
      end

      idle(); flush = 1'b0; rst_n = 1'b1; cdb_grant = 1'b1;
      repeat (8) next();
      chk("final_empty", {cdb_req, int_busy}, 2'b00);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_exec_unit_pipe.md
Name: int_exec_unit_pipe

Overview:
Parametrised, pipelined integer execution unit for the out-of-order core. It accepts one issued integer op per cycle from the integer issue queue and computes ALU results and branch outcomes. Results pass through a configurable-latency pipeline into an in-order result buffer, which arbitrates for the common data bus (CDB) with a req/grant handshake. Credit-based backpressure and a mispredict flush are new relative to the single-cycle unit.

Parameters:
XLEN, 32, datapath width (32 or 64)
TAG_W, 6, ROB/physical tag width
STAGES, 2, issue-to-CDB-request latency in cycles (1..4)
OBUF_DEPTH, 2, result buffer entries (power of two, >=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
issue_int  in  1  issue strobe; accepted when issue_int && !int_busy
int_busy  out  1  unit cannot accept an issue this cycle
Opcode  in  7  RISC-V opcode
Funct3  in  3  funct3
Funct7  in  7  funct7
RS1  in  XLEN  operand A
RS2  in  XLEN  operand B (immediate already substituted for I-type)
RD_Tag  in  TAG_W  destination tag
flush  in  1  kill all in-flight and buffered results
cdb_req  out  1  head entry requests CDB
cdb_grant  in  1  CDB arbiter grant; valid only while cdb_req
cdb_data  out  XLEN  result data
cdb_tag  out  TAG_W  result tag
cdb_valid  out  1  head is a register-writing result
cdb_branch  out  1  head is a branch outcome
cdb_branch_taken  out  1  branch resolved taken

Behaviour:
- Reset (rst_n low at posedge): all pipeline valids, buffer pointers and the occupancy counter clear. All outputs are 0, including int_busy.
- Decode. R_TYPE (0110011) and I_TYPE arith (0010011) ops are ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - SUB applies only for R_TYPE with Funct7[5]=1.
  - SRA is selected by Funct7[5]=1 with Funct3=101 for both types.
  - Shift amount is RS2[$clog2(XLEN)-1:0].
  - SLT is signed; SLTU is unsigned.
  - Any other non-branch opcode produces data 0 and is still broadcast with valid=1.
- Branch, B_TYPE (1100011): taken per Funct3.
  - 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE, 110 BLTU, 111 BGEU.
  - 010/011 give taken=0.
  - Branch entries carry data=0, tag=0, valid=0, branch=1.
- Pipeline: the result is computed combinationally at accept, then passes through STAGES-1 registers and is written into the buffer. An issue accepted at posedge N with the buffer empty shows cdb_req=1 from cycle N+STAGES.
- Buffer: in-order FIFO; the head drives the cdb_* outputs.
  - cdb_req = !empty.
  - cdb_valid = !empty && !head.branch.
  - cdb_branch = !empty && head.branch.
  - All cdb_* outputs are 0 when empty.
  - Pop on cdb_req && cdb_grant. Outputs hold stable while req is high and grant is low.
- Credit counter occ (0..OBUF_DEPTH) counts in-flight plus buffered entries: +1 on accept, -1 on pop; a simultaneous accept and pop leave it unchanged.
  - int_busy = (occ == OBUF_DEPTH), from the registered count. It is conservative: a pop in the same cycle does not unblock.
  - This guarantees the buffer never overflows. Issue while busy is ignored with no state change.
- Flush: all pipeline valids, buffer and occ are 0 next cycle.
  - An issue in the flush cycle is dropped.
  - A grant in the flush cycle counts as delivered (outputs were driven); nothing else is broadcast.
- Reset mid-operation: identical to flush plus the reset values above.
- Ordering: results leave in issue order; there is no bypass around the buffer.

Decomposition:
- Shared package holds the opcode constants (R_TYPE, I_TYPE, B_TYPE), the funct3 branch encodings and an ALU-op enum.
- A result entry struct {data, tag, valid, branch, taken} is declared locally because it is XLEN/TAG_W-parametrised.
- Sub-module int_exec_obuf: a parametrised FIFO (WIDTH, DEPTH) with push/pop/empty and head output. The ALU and branch compare stay inline.

Test Plan:
- Reset: rst_n=0 for 2 cycles with issue_int=1 -> every output 0, int_busy=0; after release, nothing is broadcast.
- ADD RS1=5, RS2=7, tag 3, grant tied 1, STAGES=2 -> cdb_req/valid=1, data=12, tag=3 exactly at issue+2 for one cycle; SUB 3-5 -> 0xFFFFFFFE; SRA 0x80000000 by 4 -> 0xF8000000.
- Branches: BNE 4,4 -> branch=1, taken=0, valid=0, data=0; BLT 0xFFFFFFFF vs 1 -> taken=1; BLTU same operands -> taken=0.
- Backpressure: OBUF_DEPTH=2, grant=0, issue 3 ops on consecutive cycles -> int_busy=1 after 2 accepts, third not accepted; raise grant -> first two broadcast in order on successive cycles, int_busy drops.
- Flush: 2 ops in flight, flush=1 plus a new issue the same cycle -> no cdb_req afterwards, occ=0, int_busy=0.
- Hold: grant=0 for 5 cycles with the head pending -> cdb_data/tag stable; a grant pulse pops exactly one entry.
